rsa_result_unloader: RTL and testbench

- Receive side of the RSA datapath; mirrors the word-serial operand loading into MonPro.
- Captures a 4096-bit MonPro result, delivered as 64 words of 64 bits on a load strobe, into an internal buffer.
- On a getResult request, streams the words to the host over a valid/ready interface.
- Sits between MonPro's res_out and the host readback logic.

---
 rtl/rsa_result_unloader.sv | 202 ++++++++++++++++++++
 tb/tb_rsa_result_unloader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_result_unloader.sv
// Captures a word-serial MonPro result into a local buffer and streams it to the host on request.
// Optional build macro UNLOAD_MSW_FIRST_EN: stream most-significant word first instead of least.
module rsa_result_unloader #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  getResult,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  full,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam int WORDS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_MAX   = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH:0]   WORDS_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef UNLOAD_MSW_FIRST_EN
   localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = PTR_MAX;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = PTR_ZERO;
`else
   localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = PTR_ZERO;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = PTR_MAX;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_READY  = 2'd2,
      S_STREAM = 2'd3
   } state_t;

   function automatic logic [ADDR_WIDTH-1:0] next_rd(input logic [ADDR_WIDTH-1:0] p);
`ifdef UNLOAD_MSW_FIRST_EN
      return p - PTR_ONE;
`else
      return p + PTR_ONE;
`endif
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [WORDS];

   state_t                state_q,      state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q,     wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q,     rd_ptr_d;
   logic                  out_valid_q,  out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q,   out_data_d;
   logic                  out_last_q,   out_last_d;
   logic                  full_q,       full_d;
   logic                  busy_q,       busy_d;
   logic                  done_q,       done_d;
   logic                  overrun_q,    overrun_d;
   logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
   logic                  mem_we_d;

   // Next-state, pointer and output computation for the capture/stream FSM.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      overrun_d   = overrun_q;
      mem_we_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ld_valid) begin
               mem_we_d = 1'b1;
               wr_ptr_d = PTR_ONE;
               state_d  = S_FILL;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_FILL: begin
            if (ld_valid) begin
               mem_we_d = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               if (wr_ptr_q == PTR_MAX) begin
                  state_d = S_READY;
               end else begin
                  state_d = S_FILL;
               end
            end else begin
               state_d = S_FILL;
            end
         end
         S_READY: begin
            if (ld_valid) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            if (getResult) begin
               state_d     = S_STREAM;
               out_valid_d = 1'b1;
               out_data_d  = mem_q[FIRST_IDX];
               out_last_d  = 1'b0;
               rd_ptr_d    = next_rd(FIRST_IDX);
            end else begin
               state_d     = S_READY;
            end
         end
         S_STREAM: begin
            if (ld_valid) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  // Leaving STREAM clears overrun even if a stray load lands in the same cycle.
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
                  rd_ptr_d    = PTR_ZERO;
                  overrun_d   = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  out_data_d  = mem_q[rd_ptr_q];
                  out_last_d  = (rd_ptr_q == LAST_IDX);
                  rd_ptr_d    = next_rd(rd_ptr_q);
                  state_d     = S_STREAM;
               end
            end else begin
               state_d = S_STREAM;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      full_d = (state_d == S_READY);
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_FILL:  word_count_d = {1'b0, wr_ptr_d};
         S_READY: word_count_d = WORDS_CNT;
         default: word_count_d = {(ADDR_WIDTH+1){1'b0}};
      endcase
   end

   // FSM and registered output state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= PTR_ZERO;
         rd_ptr_q     <= PTR_ZERO;
         out_valid_q  <= 1'b0;
         out_data_q   <= {DATA_WIDTH{1'b0}};
         out_last_q   <= 1'b0;
         full_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
         word_count_q <= {(ADDR_WIDTH+1){1'b0}};
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         full_q       <= full_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
         word_count_q <= word_count_d;
      end
   end

   // Result buffer; contents are don't-care after reset so it carries no reset.
   always_ff @(posedge clk) begin
      if (mem_we_d) begin
         mem_q[wr_ptr_q] <= ld_data;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign full       = full_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overrun    = overrun_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_rsa_result_unloader.sv
// Scoreboard bench for rsa_result_unloader: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_rsa_result_unloader;

   localparam int DW    = 64;
   localparam int AW    = 6;
   localparam int WORDS = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          getResult;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          full;
   logic          busy;
   logic          done;
   logic          overrun;
   logic [AW:0]   word_count;

   rsa_result_unloader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .getResult  (getResult),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .full       (full),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t          exp_q[$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            rx_cnt   = 0;
   int            done_cnt = 0;
   logic [DW-1:0] cur_base = 64'h95d1805142cb6d1d;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: pops the scoreboard on each accepted word and checks hold-stability under backpressure.
   initial begin : monitor
      exp_t          e;
      logic [DW-1:0] held;
      bit            stall_prev;
      stall_prev = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_prev = 1'b0;
         end else begin
            if (done) done_cnt++;
            if (stall_prev && out_valid) chk("hold_data", out_data, held);
            if (out_valid && out_ready) begin
               rx_cnt++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("stream_data", out_data, e.data);
                  chk("stream_last", {63'd0, out_last}, {63'd0, e.last});
               end
               stall_prev = 1'b0;
            end else if (out_valid) begin
               stall_prev = 1'b1;
               held       = out_data;
            end else begin
               stall_prev = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ld_valid  = 1'b0;
      ld_data   = '0;
      getResult = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_last",  {63'd0, out_last},  64'd0);
      chk("rst_full",      {63'd0, full},      64'd0);
      chk("rst_busy",      {63'd0, busy},      64'd0);
      chk("rst_done",      {63'd0, done},      64'd0);
      chk("rst_overrun",   {63'd0, overrun},   64'd0);
      chk("rst_wcount",    64'(word_count),    64'd0);
      chk("rst_out_data",  out_data,           64'd0);
      reset = 1'b0;
      tick();
   endtask

   task automatic load(input bit gapped);
      for (int i = 0; i < WORDS; i++) begin
         ld_valid = 1'b1;
         ld_data  = cur_base + 64'(i);
         tick();
         ld_valid = 1'b0;
         if (i == 0) begin
            chk("fill_busy", {63'd0, busy}, 64'd1);
            chk("fill_wc1",  64'(word_count), 64'd1);
         end
         if (i == 62) begin
            chk("fill_full_63", {63'd0, full}, 64'd0);
            chk("fill_wc_63",   64'(word_count), 64'd63);
         end
         if (i == 63) begin
            chk("full_after_64", {63'd0, full}, 64'd1);
            chk("wc_64",         64'(word_count), 64'd64);
            chk("ready_busy",    {63'd0, busy}, 64'd1);
         end
         if (gapped && i < 63) begin
            if (i == 9) begin
               chk("gap_wc10", 64'(word_count), 64'd10);
               getResult = 1'b1;
            end
            tick();
            getResult = 1'b0;
            chk("early_req_no_valid", {63'd0, out_valid}, 64'd0);
            if (i == 9) chk("gap_wc10_hold", 64'(word_count), 64'd10);
            tick();
         end
      end
   endtask

   task automatic push_expected();
      int idx;
      for (int k = 0; k < WORDS; k++) begin
`ifdef UNLOAD_MSW_FIRST_EN
         idx = WORDS - 1 - k;
`else
         idx = k;
`endif
         exp_q.push_back('{data: cur_base + 64'(idx), last: (k == WORDS - 1)});
      end
   endtask

   task automatic stream(input bit bp, input bit exp_ovr);
      bit       seen;
      bit [3:0] pat;
      pat      = 4'b1001;
      rx_cnt   = 0;
      done_cnt = 0;
      push_expected();
      out_ready = 1'b1;
      getResult = 1'b1;
      tick();
      getResult = 1'b0;
      chk("stream_valid",   {63'd0, out_valid}, 64'd1);
      chk("stream_full0",   {63'd0, full},      64'd0);
      chk("stream_busy",    {63'd0, busy},      64'd1);
      chk("stream_wc0",     64'(word_count),    64'd0);
      chk("stream_overrun", {63'd0, overrun},   {63'd0, exp_ovr});
      seen = 1'b0;
      for (int k = 0; k < 1000 && !seen; k++) begin
         out_ready = bp ? pat[3 - (k % 4)] : 1'b1;
         tick();
         seen = done;
      end
      out_ready = 1'b0;
      chk("done_seen",      {63'd0, seen},      64'd1);
      chk("end_busy",       {63'd0, busy},      64'd0);
      chk("end_valid",      {63'd0, out_valid}, 64'd0);
      chk("end_last",       {63'd0, out_last},  64'd0);
      chk("end_overrun",    {63'd0, overrun},   64'd0);
      tick();
      chk("done_one_cycle", {63'd0, done},      64'd0);
      chk("rx_count",       64'(rx_cnt),        64'd64);
      chk("done_count",     64'(done_cnt),      64'd1);
      chk("queue_empty",    64'(exp_q.size()),  64'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      do_reset();

      // Basic round trip.
      load(1'b0);
      stream(1'b0, 1'b0);

      // Gapped load with early request, overrun, then backpressured stream.
      load(1'b1);
      ld_valid = 1'b1;
      ld_data  = 64'h2aa50f4ec6f00933;
      tick();
      ld_valid = 1'b0;
      chk("overrun_set",   {63'd0, overrun}, 64'd1);
      chk("overrun_full",  {63'd0, full},    64'd1);
      chk("overrun_wc",    64'(word_count),  64'd64);
      stream(1'b1, 1'b1);

      // Reset abort mid-stream.
      load(1'b0);
      push_expected();
      rx_cnt    = 0;
      done_cnt  = 0;
      out_ready = 1'b1;
      getResult = 1'b1;
      tick();
      getResult = 1'b0;
      for (int k = 0; k < 200 && rx_cnt < 20; k++) tick();
      chk("abort_rx20", {63'd0, (rx_cnt >= 20)}, 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_last",  {63'd0, out_last},  64'd0);
      chk("abort_busy",  {63'd0, busy},      64'd0);
      chk("abort_full",  {63'd0, full},      64'd0);
      chk("abort_done",  {63'd0, done},      64'd0);
      exp_q.delete();
      out_ready = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("abort_no_done", 64'(done_cnt), 64'd0);

      // Fresh load after abort with a different data pattern.
      cur_base = 64'h0123456789abcdef;
      load(1'b0);
      stream(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
